// File: rtl/avmm_if.sv
// Avalon-MM bus bundle between an AFU-side master and a memory-side slave.
//  master modport: drives read/write/address/byteenable/burstcount/writedata,
//                  receives waitrequest/readdata/readdatavalid.
//  slave modport : the mirror image.
interface avmm_if #(
  parameter int unsigned ADDRESS_W    = 26,
  parameter int unsigned DATA_W       = 512,
  parameter int unsigned BURSTCOUNT_W = 7
) ();
  localparam int unsigned BYTEENABLE_W = DATA_W / 8;

  logic                    read;
  logic                    write;
  logic                    waitrequest;
  logic [ADDRESS_W-1:0]    address;
  logic [BYTEENABLE_W-1:0] byteenable;
  logic [BURSTCOUNT_W-1:0] burstcount;
  logic [DATA_W-1:0]       writedata;
  logic [DATA_W-1:0]       readdata;
  logic                    readdatavalid;

  modport master (
    output read, write, address, byteenable, burstcount, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, write, address, byteenable, burstcount, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avmm_rd_credit.sv
// Read-credit limiter and drain controller on the AFU-to-EMIF AVMM path.
// Ports:
//  clk, rst_n   clock and synchronous active-low reset
//  afu_reset    port reset request (pulse or level)
//  drain_busy   drain pending or in progress
//  rsp_error    sticky: readdatavalid seen with no read outstanding
//  outstanding  read beats currently in flight
//  avs          AFU-facing slave side of the bus
//  avm          checker-facing master side of the bus
// The datapath is zero latency; only command qualification and the
// credit / burst / drain bookkeeping are registered.
module avmm_rd_credit #(
  parameter int unsigned ADDRESS_W       = 26,
  parameter int unsigned DATA_W          = 512,
  parameter int unsigned BURSTCOUNT_W    = 7,
  parameter int unsigned MAX_OUTSTANDING = 128,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             afu_reset,
  output logic             drain_busy,
  output logic             rsp_error,
  output logic [CNT_W-1:0] outstanding,
  avmm_if.slave            avs,
  avmm_if.master           avm
);

  // A single maximal read burst must always fit in the credit window.
  if ((MAX_OUTSTANDING < (1 << (BURSTCOUNT_W - 1))) || (ADDRESS_W == 0) ||
      ((DATA_W % 8) != 0)) begin : g_bad_cfg
    $error("avmm_rd_credit: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    WBURST = 3'b010,
    DRAIN  = 3'b100
  } state_t;

  state_t                  state;
  logic [BURSTCOUNT_W-1:0] wrem;
  logic                    rst_pend;

  logic [CNT_W:0] bc_ext;
  logic [CNT_W:0] rd_sum;
  logic           rd_ok;
  logic           in_drain;
  logic           rd_acc;
  logic           wr_acc;
  logic [CNT_W:0] out_add;
  logic [CNT_W:0] out_nxt;
  logic           rsp_err_set;
  logic           idle_burst;
  logic           idle_drain;
  logic           burst_end;
  logic           burst_drain;
  logic           enter_drain;
  logic           drain_exit;
  logic           drain_nxt;
  logic           rst_pend_nxt;

  // Zero-latency pass-through
  assign avm.address    = avs.address;
  assign avm.byteenable = avs.byteenable;
  assign avm.burstcount = avs.burstcount;
  assign avm.writedata  = avs.writedata;
  assign avs.readdata      = avm.readdata;
  assign avs.readdatavalid = avm.readdatavalid;

  // Credit check in CNT_W+1 bits so a large burst cannot wrap the sum
  assign bc_ext   = (CNT_W + 1)'(avs.burstcount);
  assign rd_sum   = {1'b0, outstanding} + bc_ext;
  assign rd_ok    = rd_sum <= (CNT_W + 1)'(MAX_OUTSTANDING);
  assign in_drain = (state == DRAIN);

  assign avm.read        = avs.read & rd_ok & ~in_drain;
  assign avm.write       = avs.write & ~in_drain;
  assign avs.waitrequest = avm.waitrequest | (avs.read & ~rd_ok) | in_drain;

  assign rd_acc = avm.read & ~avm.waitrequest;
  assign wr_acc = avm.write & ~avm.waitrequest;

  // Net outstanding update; a stray response with nothing in flight holds at 0
  assign out_add     = {1'b0, outstanding} + (rd_acc ? bc_ext : '0);
  assign out_nxt     = !avm.readdatavalid ? out_add :
                       (out_add == '0)    ? '0 : out_add - (CNT_W + 1)'(1);
  assign rsp_err_set = avm.readdatavalid & (outstanding == '0) & ~rd_acc;

  // FSM transition terms
  assign idle_burst  = (state == IDLE) & wr_acc & (avs.burstcount > BURSTCOUNT_W'(1));
  assign idle_drain  = (state == IDLE) & ~idle_burst & (afu_reset | rst_pend);
  assign burst_end   = (state == WBURST) & wr_acc & (wrem == BURSTCOUNT_W'(1));
  assign burst_drain = burst_end & (rst_pend | afu_reset);
  assign enter_drain = idle_drain | burst_drain;
  assign drain_exit  = in_drain & (outstanding == '0) & ~afu_reset;
  assign drain_nxt   = enter_drain | (in_drain & ~drain_exit);

  // A request is remembered until the drain actually starts
  assign rst_pend_nxt = enter_drain ? 1'b0 : (rst_pend | (afu_reset & ~in_drain));

  // State, credit counter and status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wrem        <= '0;
      rst_pend    <= 1'b0;
      rsp_error   <= 1'b0;
      drain_busy  <= 1'b0;
      outstanding <= '0;
    end else begin
      outstanding <= CNT_W'(out_nxt);
      rst_pend    <= rst_pend_nxt;
      drain_busy  <= rst_pend_nxt | drain_nxt | afu_reset;

      if (rsp_err_set) begin
        rsp_error <= 1'b1;
      end else if (drain_exit) begin
        rsp_error <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (idle_burst) begin
            state <= WBURST;
            wrem  <= avs.burstcount - BURSTCOUNT_W'(1);
          end else if (idle_drain) begin
            state <= DRAIN;
          end
        end
        WBURST: begin
          // afu_reset never cuts a write burst short
          if (wr_acc) begin
            wrem <= wrem - BURSTCOUNT_W'(1);
            if (burst_end) begin
              state <= burst_drain ? DRAIN : IDLE;
            end
          end
        end
        DRAIN: begin
          if (drain_exit) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
